// File: rtl/ifetch_queue.sv
// Fetch front end: one icache request in flight, next-PC resolution for jal/branch/jalr,
// and a circular instruction queue that decouples the icache from the decoder.
module ifetch_queue #(
  parameter int ADDR_WIDTH = 32,
  parameter int QUEUE_DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  rdy_in,
  output logic                  ic_req,
  output logic [ADDR_WIDTH-1:0] ic_pc,
  input  logic                  ic_valid,
  input  logic [31:0]           ic_inst,
  output logic                  pred_query,
  output logic [ADDR_WIDTH-1:0] pred_pc,
  input  logic                  pred_taken,
  output logic                  pred_update,
  output logic [ADDR_WIDTH-1:0] pred_update_pc,
  output logic                  pred_update_taken,
  output logic                  dec_valid,
  output logic [31:0]           dec_inst,
  output logic [ADDR_WIDTH-1:0] dec_pc,
  output logic                  dec_pred_taken,
  input  logic                  dec_ready,
  input  logic                  rob_br_done,
  input  logic [ADDR_WIDTH-1:0] rob_br_pc,
  input  logic                  rob_br_taken,
  input  logic                  rob_redirect,
  input  logic [ADDR_WIDTH-1:0] rob_redirect_pc,
  input  logic                  jalr_done,
  input  logic [ADDR_WIDTH-1:0] jalr_target
);
  // state   | meaning
  // S_REQ   | issue a fetch for pc once the queue has room
  // S_WAIT  | fetch outstanding, decode the response
  // S_PRED  | branch held, query predictor and wait for its answer
  // S_JALR  | jalr queued, stall until its target is known
  // S_DRAIN | stale fetch outstanding after a redirect, drop its response
  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(QUEUE_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] FOUR = ADDR_WIDTH'(4);
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_BR   = 7'b1100011;

  typedef enum logic [2:0] {S_REQ, S_WAIT, S_PRED, S_JALR, S_DRAIN} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] pc;
  logic [31:0]           br_inst;
  logic [1:0]            pred_ph;
  logic [31:0]           q_inst [QUEUE_DEPTH];
  logic [ADDR_WIDTH-1:0] q_pc   [QUEUE_DEPTH];
  logic [QUEUE_DEPTH-1:0] q_taken;
  logic [PW-1:0]         head, tail;
  logic [CW-1:0]         count;
  logic                  ubuf_v;
  logic [ADDR_WIDTH-1:0] ubuf_pc;
  logic                  ubuf_taken;

  logic [ADDR_WIDTH-1:0] imm_j, imm_b;
  logic wait_hit, is_jal, is_jalr, is_br;
  logic q_want, q_block, q_fire;
  logic push, pop, push_taken;
  logic [31:0] push_inst;

  assign imm_j = {{(ADDR_WIDTH-20){ic_inst[31]}}, ic_inst[19:12], ic_inst[20], ic_inst[30:21], 1'b0};
  assign imm_b = {{(ADDR_WIDTH-12){br_inst[31]}}, br_inst[7], br_inst[30:25], br_inst[11:8], 1'b0};
  assign wait_hit = (state == S_WAIT) && ic_valid;
  assign is_jal   = (ic_inst[6:0] == OP_JAL);
  assign is_jalr  = (ic_inst[6:0] == OP_JALR);
  assign is_br    = (ic_inst[6:0] == OP_BR);

  // pred_ph: 0 = query not yet issued, 1 = query on the bus, 2 = prediction valid.
  // A query is postponed only when the single update buffer could not absorb the collision.
  assign q_want  = (wait_hit && is_br) || (state == S_PRED && pred_ph == 2'd0);
  assign q_block = ubuf_v && rob_br_done;
  assign q_fire  = q_want && !q_block && !rob_redirect;

  assign pop = dec_valid && dec_ready;

  always_comb begin
    push       = 1'b0;
    push_inst  = ic_inst;
    push_taken = 1'b0;
    if (wait_hit && !is_br) begin
      push = 1'b1;
    end else if (state == S_PRED && pred_ph == 2'd2) begin
      push       = 1'b1;
      push_inst  = br_inst;
      push_taken = pred_taken;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_n_in && rdy_in && push && !rob_redirect) begin
      q_inst[tail]  <= push_inst;
      q_pc[tail]    <= pc;
      q_taken[tail] <= push_taken;
    end
  end

  assign dec_valid      = (count != '0);
  assign dec_inst       = dec_valid ? q_inst[head] : '0;
  assign dec_pc         = dec_valid ? q_pc[head] : '0;
  assign dec_pred_taken = dec_valid & q_taken[head];

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state             <= S_REQ;
      pc                <= RESET_PC;
      br_inst           <= '0;
      pred_ph           <= 2'd0;
      head              <= '0;
      tail              <= '0;
      count             <= '0;
      ubuf_v            <= 1'b0;
      ubuf_pc           <= '0;
      ubuf_taken        <= 1'b0;
      ic_req            <= 1'b0;
      ic_pc             <= '0;
      pred_query        <= 1'b0;
      pred_pc           <= '0;
      pred_update       <= 1'b0;
      pred_update_pc    <= '0;
      pred_update_taken <= 1'b0;
    end else if (rdy_in) begin
      ic_req     <= 1'b0;
      pred_query <= q_fire;
      if (q_fire) pred_pc <= pc;

      // Training path: buffered entry always leaves first, so updates stay in order.
      if (ubuf_v) begin
        if (q_fire) begin
          pred_update <= 1'b0;
        end else begin
          pred_update       <= 1'b1;
          pred_update_pc    <= ubuf_pc;
          pred_update_taken <= ubuf_taken;
          ubuf_v            <= rob_br_done;
          ubuf_pc           <= rob_br_pc;
          ubuf_taken        <= rob_br_taken;
        end
      end else if (rob_br_done) begin
        if (q_fire) begin
          pred_update <= 1'b0;
          ubuf_v      <= 1'b1;
          ubuf_pc     <= rob_br_pc;
          ubuf_taken  <= rob_br_taken;
        end else begin
          pred_update       <= 1'b1;
          pred_update_pc    <= rob_br_pc;
          pred_update_taken <= rob_br_taken;
        end
      end else begin
        pred_update <= 1'b0;
      end

      if (rob_redirect) begin
        count   <= '0;
        head    <= '0;
        tail    <= '0;
        pc      <= rob_redirect_pc;
        pred_ph <= 2'd0;
        state   <= ((state == S_WAIT || state == S_DRAIN) && !ic_valid) ? S_DRAIN : S_REQ;
      end else begin
        if (push) tail <= tail + PW'(1);
        if (pop) head <= head + PW'(1);
        if (push && !pop) count <= count + CW'(1);
        else if (!push && pop) count <= count - CW'(1);

        case (state)
          S_REQ: begin
            if (count < DEPTH_C) begin
              ic_req <= 1'b1;
              ic_pc  <= pc;
              state  <= S_WAIT;
            end
          end
          S_WAIT: begin
            if (ic_valid) begin
              if (is_jal) begin
                pc    <= pc + imm_j;
                state <= S_REQ;
              end else if (is_jalr) begin
                state <= S_JALR;
              end else if (is_br) begin
                br_inst <= ic_inst;
                pred_ph <= q_fire ? 2'd1 : 2'd0;
                state   <= S_PRED;
              end else begin
                pc    <= pc + FOUR;
                state <= S_REQ;
              end
            end
          end
          S_PRED: begin
            case (pred_ph)
              2'd0: if (q_fire) pred_ph <= 2'd1;
              2'd1: pred_ph <= 2'd2;
              default: begin
                pc      <= pred_taken ? pc + imm_b : pc + FOUR;
                pred_ph <= 2'd0;
                state   <= S_REQ;
              end
            endcase
          end
          S_JALR: begin
            if (jalr_done) begin
              pc    <= jalr_target;
              state <= S_REQ;
            end
          end
          S_DRAIN: begin
            if (ic_valid) state <= S_REQ;
          end
          default: state <= S_REQ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue: vector table of single-instruction fetches plus
// hand-written sequences for queue full, update collision, redirect flush and reset.
module tb_ifetch_queue;
  logic        clk_in = 1'b0;
  logic        rst_n_in, rdy_in;
  logic        ic_req;
  logic [31:0] ic_pc;
  logic        ic_valid;
  logic [31:0] ic_inst;
  logic        pred_query;
  logic [31:0] pred_pc;
  logic        pred_taken;
  logic        pred_update;
  logic [31:0] pred_update_pc;
  logic        pred_update_taken;
  logic        dec_valid;
  logic [31:0] dec_inst;
  logic [31:0] dec_pc;
  logic        dec_pred_taken;
  logic        dec_ready;
  logic        rob_br_done;
  logic [31:0] rob_br_pc;
  logic        rob_br_taken;
  logic        rob_redirect;
  logic [31:0] rob_redirect_pc;
  logic        jalr_done;
  logic [31:0] jalr_target;

  always #5 clk_in = ~clk_in;

  ifetch_queue #(.ADDR_WIDTH(32), .QUEUE_DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in),
    .ic_req(ic_req), .ic_pc(ic_pc), .ic_valid(ic_valid), .ic_inst(ic_inst),
    .pred_query(pred_query), .pred_pc(pred_pc), .pred_taken(pred_taken),
    .pred_update(pred_update), .pred_update_pc(pred_update_pc),
    .pred_update_taken(pred_update_taken),
    .dec_valid(dec_valid), .dec_inst(dec_inst), .dec_pc(dec_pc),
    .dec_pred_taken(dec_pred_taken), .dec_ready(dec_ready),
    .rob_br_done(rob_br_done), .rob_br_pc(rob_br_pc), .rob_br_taken(rob_br_taken),
    .rob_redirect(rob_redirect), .rob_redirect_pc(rob_redirect_pc),
    .jalr_done(jalr_done), .jalr_target(jalr_target)
  );

  localparam logic [31:0] ADDI     = 32'h0010_8093;
  localparam logic [31:0] BR_FWD   = 32'h0200_0063; // beq +0x20
  localparam logic [31:0] BR_BACK  = 32'hFE00_0CE3; // beq -8
  localparam logic [31:0] JAL_M4   = 32'hFFDF_F06F; // jal -4
  localparam logic [31:0] JAL_P8   = 32'h0080_006F; // jal +8
  localparam logic [31:0] JAL_P800 = 32'h0010_006F; // jal +0x800
  localparam logic [31:0] JALR     = 32'h0000_8067;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        taken;
  } ent_t;

  typedef struct {
    logic [31:0] start;
    logic [31:0] inst;
    logic        ptaken;
    logic        is_br;
    logic        is_jalr;
    logic [31:0] jtgt;
    logic [31:0] nxt;
    logic        exp_taken;
  } vec_t;

  int total = 0;
  int bad = 0;
  ent_t popped[$];
  logic [31:0] last_qpc;

  always @(negedge clk_in) begin
    #1;
    if (dec_valid && dec_ready) popped.push_back('{dec_pc, dec_inst, dec_pred_taken});
    if (pred_query) begin
      last_qpc = pred_pc;
      total++;
      if (pred_update) begin
        bad++;
        $display("FAIL query_update_overlap: pred_update=%0b with pred_query, want 0", pred_update);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic wait_req(output logic [31:0] a);
    a = 32'hDEAD_BEEF;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_in);
      if (ic_req) begin
        a = ic_pc;
        return;
      end
    end
    total++;
    bad++;
    $display("FAIL req_timeout: got no ic_req want one within 40 cycles");
  endtask

  task automatic respond(input logic [31:0] inst);
    @(negedge clk_in);
    ic_valid = 1'b1;
    ic_inst  = inst;
    @(negedge clk_in);
    ic_valid = 1'b0;
  endtask

  task automatic count_req(input int n, output int c);
    c = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk_in);
      if (ic_req) c++;
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ic"}, {ic_req, ic_pc}, 0);
    chk({tag, "_pq"}, {pred_query, pred_pc}, 0);
    chk({tag, "_pu"}, {pred_update, pred_update_pc, pred_update_taken}, 0);
    chk({tag, "_dec"}, {dec_valid, dec_pred_taken, dec_pc}, 0);
    chk({tag, "_dinst"}, dec_inst, 0);
  endtask

  task automatic do_reset();
    rst_n_in = 1'b0; rdy_in = 1'b1; ic_valid = 1'b0; ic_inst = '0;
    rob_br_done = 1'b0; rob_redirect = 1'b0; jalr_done = 1'b0;
    repeat (2) @(negedge clk_in);
    rst_n_in = 1'b1;
    popped.delete();
  endtask

  // Park the fetcher at `start` via a redirect over the reset fetch, dropping its response.
  task automatic go_to(input logic [31:0] start);
    logic [31:0] a;
    do_reset();
    wait_req(a);
    rob_redirect = 1'b1;
    rob_redirect_pc = start;
    @(negedge clk_in);
    rob_redirect = 1'b0;
    @(negedge clk_in);
    ic_valid = 1'b1;
    ic_inst = ADDI;
    @(negedge clk_in);
    ic_valid = 1'b0;
    popped.delete();
  endtask

  initial begin
    vec_t vt[8];
    logic [31:0] a;
    int c;
    ent_t e;

    vt[0] = '{32'h40,       ADDI,     1'b0, 1'b0, 1'b0, 32'h0,   32'h44,  1'b0};
    vt[1] = '{32'h8,        BR_FWD,   1'b1, 1'b1, 1'b0, 32'h0,   32'h28,  1'b1};
    vt[2] = '{32'h8,        BR_FWD,   1'b0, 1'b1, 1'b0, 32'h0,   32'hC,   1'b0};
    vt[3] = '{32'h100,      BR_BACK,  1'b1, 1'b1, 1'b0, 32'h0,   32'hF8,  1'b1};
    vt[4] = '{32'h4,        JAL_M4,   1'b0, 1'b0, 1'b0, 32'h0,   32'h0,   1'b0};
    vt[5] = '{32'hFFFFFFFC, JAL_P8,   1'b0, 1'b0, 1'b0, 32'h0,   32'h4,   1'b0};
    vt[6] = '{32'h10,       JALR,     1'b0, 1'b0, 1'b1, 32'h100, 32'h100, 1'b0};
    vt[7] = '{32'h20,       JAL_P800, 1'b0, 1'b0, 1'b0, 32'h0,   32'h820, 1'b0};

    dec_ready = 1'b1; pred_taken = 1'b0;
    rob_br_pc = '0; rob_br_taken = 1'b0; rob_redirect_pc = '0; jalr_target = '0;

    // Reset state, then pause straight after reset.
    do_reset();
    rst_n_in = 1'b0;
    @(negedge clk_in);
    check_all_zero("reset");
    rdy_in = 1'b0;
    rst_n_in = 1'b1;
    count_req(4, c);
    chk("pause_no_req", c, 0);
    rdy_in = 1'b1;
    wait_req(a);
    chk("pause_resume_pc", a, 32'h0);
    rdy_in = 1'b0;
    @(negedge clk_in);
    chk("pause_hold_req", ic_req, 1);
    rdy_in = 1'b1;
    @(negedge clk_in);
    chk("pause_req_low", ic_req, 0);

    // Straight-line stream.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      wait_req(a);
      chk("seq_pc", a, 32'(i * 4));
      respond(ADDI);
    end
    wait_req(a);
    chk("seq_next", a, 32'h10);
    chk("seq_count", popped.size(), 4);
    for (int i = 0; i < 4 && popped.size() > 0; i++) begin
      e = popped.pop_front();
      chk("seq_dec_pc", e.pc, 32'(i * 4));
      chk("seq_dec_taken", e.taken, 0);
    end

    // Queue full: four pushes, then no fetch until the decoder drains.
    do_reset();
    dec_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wait_req(a);
      respond(ADDI);
    end
    count_req(8, c);
    chk("full_no_req", c, 0);
    chk("full_head", {dec_valid, dec_pc}, {1'b1, 32'h0});
    dec_ready = 1'b1;
    wait_req(a);
    chk("full_resume_pc", a, 32'h10);
    if (popped.size() > 0) begin
      e = popped.pop_front();
      chk("full_first_pop", e.pc, 32'h0);
    end else begin
      chk("full_first_pop_cnt", popped.size(), 1);
    end

    // Vector table: one instruction each, check queued entry and next fetch address.
    for (int i = 0; i < 8; i++) begin
      pred_taken = vt[i].ptaken;
      go_to(vt[i].start);
      last_qpc = 32'hFFFF_FFFF;
      wait_req(a);
      chk("vec_req", a, vt[i].start);
      respond(vt[i].inst);
      if (vt[i].is_jalr) begin
        count_req(5, c);
        chk("vec_jalr_stall", c, 0);
        @(negedge clk_in);
        jalr_done = 1'b1;
        jalr_target = vt[i].jtgt;
        @(negedge clk_in);
        jalr_done = 1'b0;
      end
      wait_req(a);
      chk("vec_next_pc", a, vt[i].nxt);
      if (vt[i].is_br) chk("vec_pred_pc", last_qpc, vt[i].start);
      chk("vec_count", popped.size(), 1);
      if (popped.size() > 0) begin
        e = popped.pop_front();
        chk("vec_entry", {e.pc, e.taken}, {vt[i].start, vt[i].exp_taken});
        chk("vec_inst", e.inst, vt[i].inst);
      end
    end

    // Update colliding with a query is held one cycle; the next update follows in order.
    pred_taken = 1'b1;
    go_to(32'h8);
    wait_req(a);
    @(negedge clk_in);
    ic_valid = 1'b1; ic_inst = BR_FWD;
    rob_br_done = 1'b1; rob_br_pc = 32'h500; rob_br_taken = 1'b1;
    @(negedge clk_in);
    ic_valid = 1'b0;
    rob_br_pc = 32'h600; rob_br_taken = 1'b0;
    chk("coll_query", {pred_query, pred_update}, 2'b10);
    @(negedge clk_in);
    rob_br_done = 1'b0;
    chk("coll_upd1", {pred_update, pred_update_pc, pred_update_taken}, {1'b1, 32'h500, 1'b1});
    @(negedge clk_in);
    chk("coll_upd2", {pred_update, pred_update_pc, pred_update_taken}, {1'b1, 32'h600, 1'b0});
    wait_req(a);
    chk("coll_next_pc", a, 32'h28);

    // Redirect mid-WAIT with a non-empty queue and a same-cycle branch resolution.
    do_reset();
    dec_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      wait_req(a);
      respond(ADDI);
    end
    wait_req(a);
    chk("redir_prefill", {dec_valid, a}, {1'b1, 32'h8});
    rob_redirect = 1'b1; rob_redirect_pc = 32'h200;
    rob_br_done = 1'b1; rob_br_pc = 32'h8; rob_br_taken = 1'b1;
    @(negedge clk_in);
    rob_redirect = 1'b0; rob_br_done = 1'b0;
    chk("redir_flush", dec_valid, 0);
    chk("redir_update", {pred_update, pred_update_pc, pred_update_taken}, {1'b1, 32'h8, 1'b1});
    @(negedge clk_in);
    chk("redir_update_pulse", pred_update, 0);
    @(negedge clk_in);
    ic_valid = 1'b1; ic_inst = JAL_M4;
    @(negedge clk_in);
    ic_valid = 1'b0;
    dec_ready = 1'b1;
    wait_req(a);
    chk("redir_next_pc", a, 32'h200);
    chk("redir_stale_dropped", {dec_valid, 32'(popped.size())}, 0);

    // Reset in the middle of WAIT.
    rst_n_in = 1'b0;
    @(negedge clk_in);
    check_all_zero("midrst");
    rst_n_in = 1'b1;
    wait_req(a);
    chk("midrst_pc", a, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
